// File: rtl/arp_resolver_pkg.sv
// ARP resolver shared package: FSM encoding and broadcast constants.
// Imported by arp_resolver, arp_resolver_if and arp_retry_timer.
package arp_resolver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_QUERY,
    ST_WAIT_RESP,
    ST_SEND_REQ,
    ST_WAIT_REPLY,
    ST_RESPOND
  } arp_state_t;

  localparam logic [31:0] BCAST_IP  = 32'hFFFF_FFFF;
  localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  function automatic logic is_bcast(
    input logic [31:0] ip,
    input logic [31:0] mask
  );
    return (ip | mask) == BCAST_IP;
  endfunction

endpackage

// File: rtl/arp_resolver_if.sv
// ARP resolver bus bundle: request/response, cache query/fill,
// ARP frame trigger, received-reply pulse and IP configuration.
interface arp_resolver_if;
  import arp_resolver_pkg::*;

  logic        arp_request_valid;
  logic        arp_request_ready;
  logic [31:0] arp_request_ip;

  logic        arp_response_valid;
  logic        arp_response_ready;
  logic        arp_response_error;
  logic [47:0] arp_response_mac;

  logic        cache_query_request_valid;
  logic        cache_query_request_ready;
  logic [31:0] cache_query_request_ip;

  logic        cache_query_response_valid;
  logic        cache_query_response_ready;
  logic        cache_query_response_error;
  logic [47:0] cache_query_response_mac;

  logic        cache_write_request_valid;
  logic        cache_write_request_ready;
  logic [31:0] cache_write_request_ip;
  logic [47:0] cache_write_request_mac;

  logic        arp_tx_valid;
  logic        arp_tx_ready;
  logic [31:0] arp_tx_target_ip;

  logic        arp_reply_valid;
  logic [31:0] arp_reply_ip;
  logic [47:0] arp_reply_mac;

  logic [31:0] local_ip;
  logic [31:0] gateway_ip;
  logic [31:0] subnet_mask;

  modport slave (
    input  arp_request_valid, arp_request_ip,
    output arp_request_ready,
    output arp_response_valid, arp_response_error,
    output arp_response_mac,
    input  arp_response_ready,
    output cache_query_request_valid, cache_query_request_ip,
    input  cache_query_request_ready,
    input  cache_query_response_valid,
    input  cache_query_response_error,
    input  cache_query_response_mac,
    output cache_query_response_ready,
    output cache_write_request_valid, cache_write_request_ip,
    output cache_write_request_mac,
    input  cache_write_request_ready,
    output arp_tx_valid, arp_tx_target_ip,
    input  arp_tx_ready,
    input  arp_reply_valid, arp_reply_ip, arp_reply_mac,
    input  local_ip, gateway_ip, subnet_mask
  );

  modport master (
    output arp_request_valid, arp_request_ip,
    input  arp_request_ready,
    input  arp_response_valid, arp_response_error,
    input  arp_response_mac,
    output arp_response_ready,
    input  cache_query_request_valid, cache_query_request_ip,
    output cache_query_request_ready,
    output cache_query_response_valid,
    output cache_query_response_error,
    output cache_query_response_mac,
    input  cache_query_response_ready,
    input  cache_write_request_valid, cache_write_request_ip,
    input  cache_write_request_mac,
    output cache_write_request_ready,
    input  arp_tx_valid, arp_tx_target_ip,
    output arp_tx_ready,
    output arp_reply_valid, arp_reply_ip, arp_reply_mac,
    output local_ip, gateway_ip, subnet_mask
  );

endinterface

// File: rtl/arp_retry_timer.sv
// Retry timer: loadable down-counter that stops at zero and
// flags when it is there.
module arp_retry_timer
  import arp_resolver_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/arp_resolver.sv
// ARP resolver: cache lookup, ARP request retries, reply capture.
// Define ARP_GATEWAY_EN to route off-subnet lookups via gateway_ip.
module arp_resolver
  import arp_resolver_pkg::*;
#(
  parameter int RETRY_COUNT    = 4,
  parameter int RETRY_INTERVAL = 250000000,
  parameter int TIMER_WIDTH    = 32
) (
  input logic           clk,
  input logic           rst,
  arp_resolver_if.slave bus
);

  localparam int RW =
    (RETRY_COUNT > 1) ? $clog2(RETRY_COUNT) : 1;

  arp_state_t  r_state;
  logic [31:0] r_ip;
  logic [RW-1:0] r_retry;
  logic        r_req_ready;
  logic        r_cq_valid;
  logic        r_cr_ready;
  logic        r_tx_valid;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [47:0] r_resp_mac;

  logic        r_wb_valid;
  logic [31:0] r_wb_ip;
  logic [47:0] r_wb_mac;

  logic [31:0] w_lookup_ip;
  logic        w_bcast;
  logic        w_match;
  logic        w_load;
  logic        w_zero;
  logic        w_drain;

`ifdef ARP_GATEWAY_EN
  logic w_offnet;
  assign w_offnet =
    ((bus.arp_request_ip ^ bus.local_ip)
      & bus.subnet_mask) != '0;
  assign w_lookup_ip =
    w_offnet ? bus.gateway_ip : bus.arp_request_ip;
  assign w_bcast =
    is_bcast(bus.arp_request_ip, bus.subnet_mask);
`else
  logic w_unused_cfg;
  assign w_unused_cfg =
    ^{bus.local_ip, bus.gateway_ip, bus.subnet_mask};
  assign w_lookup_ip = bus.arp_request_ip;
  assign w_bcast     = (bus.arp_request_ip == BCAST_IP);
`endif

  assign w_match = bus.arp_reply_valid
                && (bus.arp_reply_ip == r_ip);
  assign w_load  = (r_state == ST_SEND_REQ)
                && r_tx_valid && bus.arp_tx_ready;

  arp_retry_timer #(
    .WIDTH (TIMER_WIDTH)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_value (TIMER_WIDTH'(RETRY_INTERVAL - 1)),
    .o_zero  (w_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_ip         <= '0;
      r_retry      <= '0;
      r_req_ready  <= 1'b0;
      r_cq_valid   <= 1'b0;
      r_cr_ready   <= 1'b0;
      r_tx_valid   <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_mac   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_req_ready <= 1'b1;
          if (r_req_ready && bus.arp_request_valid) begin
            r_req_ready <= 1'b0;
            r_ip        <= w_lookup_ip;
            if (w_bcast) begin
              r_state      <= ST_RESPOND;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b0;
              r_resp_mac   <= BCAST_MAC;
            end else begin
              r_state    <= ST_QUERY;
              r_cq_valid <= 1'b1;
            end
          end
        end
        ST_QUERY: begin
          if (bus.cache_query_request_ready) begin
            r_cq_valid <= 1'b0;
            r_cr_ready <= 1'b1;
            r_state    <= ST_WAIT_RESP;
          end
        end
        ST_WAIT_RESP: begin
          if (bus.cache_query_response_valid) begin
            r_cr_ready <= 1'b0;
            if (!bus.cache_query_response_error) begin
              r_state      <= ST_RESPOND;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b0;
              r_resp_mac   <= bus.cache_query_response_mac;
            end else begin
              r_state    <= ST_SEND_REQ;
              r_retry    <= RW'(RETRY_COUNT - 1);
              r_tx_valid <= 1'b1;
            end
          end
        end
        ST_SEND_REQ: begin
          if (bus.arp_tx_ready) begin
            r_tx_valid <= 1'b0;
            r_state    <= ST_WAIT_REPLY;
          end
        end
        ST_WAIT_REPLY: begin
          // A matching reply wins over a same-cycle expiry.
          if (w_match) begin
            r_state      <= ST_RESPOND;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_mac   <= bus.arp_reply_mac;
          end else if (w_zero) begin
            if (r_retry == '0) begin
              r_state      <= ST_RESPOND;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_mac   <= '0;
            end else begin
              r_retry    <= r_retry - RW'(1);
              r_state    <= ST_SEND_REQ;
              r_tx_valid <= 1'b1;
            end
          end
        end
        ST_RESPOND: begin
          if (bus.arp_response_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_cq_valid   <= 1'b0;
          r_cr_ready   <= 1'b0;
          r_tx_valid   <= 1'b0;
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign w_drain = r_wb_valid && bus.cache_write_request_ready;

  // Single-entry fill buffer; a full, stalled buffer drops new replies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_valid <= 1'b0;
      r_wb_ip    <= '0;
      r_wb_mac   <= '0;
    end else if (bus.arp_reply_valid
                 && (!r_wb_valid || w_drain)) begin
      r_wb_valid <= 1'b1;
      r_wb_ip    <= bus.arp_reply_ip;
      r_wb_mac   <= bus.arp_reply_mac;
    end else if (w_drain) begin
      r_wb_valid <= 1'b0;
    end
  end

  assign bus.arp_request_ready          = r_req_ready;
  assign bus.cache_query_request_valid  = r_cq_valid;
  assign bus.cache_query_request_ip     = r_ip;
  assign bus.cache_query_response_ready = r_cr_ready;
  assign bus.arp_tx_valid               = r_tx_valid;
  assign bus.arp_tx_target_ip           = r_ip;
  assign bus.arp_response_valid         = r_resp_valid;
  assign bus.arp_response_error         = r_resp_err;
  assign bus.arp_response_mac           = r_resp_mac;
  assign bus.cache_write_request_valid  = r_wb_valid;
  assign bus.cache_write_request_ip     = r_wb_ip;
  assign bus.cache_write_request_mac    = r_wb_mac;

endmodule
